lcd_scanout: RTL and testbench



---
 rtl/lcd_pkg.sv | 35 +++
 rtl/nes_palette_rom.sv | 36 +++
 rtl/lcd_scanout.sv | 144 ++++++++++++++
 tb/tb_lcd_scanout.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD scan-out path.
//   - Default 480x272 panel timing and NES image placement.
//   - RGB width/type and the 64-entry NES palette (index -> 24-bit {R,G,B}).
package lcd_pkg;

  localparam int unsigned LcdHActive = 480;
  localparam int unsigned LcdHFp     = 2;
  localparam int unsigned LcdHSync   = 41;
  localparam int unsigned LcdHBp     = 2;
  localparam int unsigned LcdVActive = 272;
  localparam int unsigned LcdVFp     = 2;
  localparam int unsigned LcdVSync   = 10;
  localparam int unsigned LcdVBp     = 2;
  localparam int unsigned LcdImgX0   = 112;
  localparam int unsigned LcdImgY0   = 16;

  // NES frame size in the video buffer
  localparam int unsigned ImgW = 256;
  localparam int unsigned ImgH = 240;

  localparam int unsigned RgbWidth = 24;
  typedef logic [RgbWidth-1:0] rgb_t;

  localparam rgb_t NesPalette [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

endpackage

// File: rtl/nes_palette_rom.sv
// nes_palette_rom: registered NES palette lookup (last pipeline stage).
//   clk_i   - pixel clock
//   rst_i   - synchronous active-high reset, clears the output
//   valid_i - pixel lies inside the NES image; otherwise the output is black
//   idx_i   - 6-bit NES palette index
//   rgb_o   - registered 24-bit {R,G,B}
module nes_palette_rom
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [5:0] idx_i,
  output rgb_t       rgb_o
);

  rgb_t rgb_d, rgb_q;

  always_comb begin
    rgb_d = '0;
    if (valid_i) begin
      rgb_d = NesPalette[idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/lcd_scanout.sv
// lcd_scanout: LCD panel timing generator and NES frame scan-out.
//   i_lcd_clk     - pixel clock (single clock domain)
//   i_rst         - synchronous active-high reset
//   i_wbank       - bank the PPU is writing; we read the other one
//   o_raddr       - buffer read address {bank, y, x}
//   i_rdata       - buffer data, valid one clock after o_raddr
//   o_hsync       - active-low horizontal sync
//   o_vsync       - active-low vertical sync
//   o_de          - data enable on visible panel pixels
//   o_rgb         - {R,G,B}, black outside the NES image
//   o_frame_start - one-clock pulse on the first visible pixel of a frame
// Pipeline: T0 counters, T1 address, T2 RAM data, T3 colour. Syncs and enables
// are delayed three clocks so they line up with o_rgb.
module lcd_scanout
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LcdHActive,
  parameter int unsigned H_FP     = LcdHFp,
  parameter int unsigned H_SYNC   = LcdHSync,
  parameter int unsigned H_BP     = LcdHBp,
  parameter int unsigned V_ACTIVE = LcdVActive,
  parameter int unsigned V_FP     = LcdVFp,
  parameter int unsigned V_SYNC   = LcdVSync,
  parameter int unsigned V_BP     = LcdVBp,
  parameter int unsigned IMG_X0   = LcdImgX0,
  parameter int unsigned IMG_Y0   = LcdImgY0
) (
  input  logic                i_lcd_clk,
  input  logic                i_rst,
  input  logic                i_wbank,
  output logic [16:0]         o_raddr,
  input  logic [7:0]          i_rdata,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_de,
  output logic [RgbWidth-1:0] o_rgb,
  output logic                o_frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  localparam logic [HW-1:0] HLast = HW'(HTotal - 1);
  localparam logic [VW-1:0] VLast = VW'(VTotal - 1);

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
    logic frame_start;
  } side_t;

  localparam side_t SideIdle = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0, frame_start: 1'b0};

  logic [HW-1:0] hcnt_d, hcnt_q;
  logic [VW-1:0] vcnt_d, vcnt_q;
  logic          rbank_d, rbank_q;
  logic [16:0]   raddr_d, raddr_q;
  side_t         side0, side1_q, side2_q, side3_q;
  logic          img0, img1_q, img2_q;

  logic [31:0] h32, v32;
  logic [7:0]  x0, y0;
  logic        frame_end;

  // Only the palette index matters; the top two data bits are don't-care.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^i_rdata[7:6];

  // T0 decode, done at 32 bits so small test geometries never truncate limits.
  always_comb begin
    h32 = 32'(hcnt_q);
    v32 = 32'(vcnt_q);

    side0.de          = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    side0.hsync_n     = !((h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC));
    side0.vsync_n     = !((v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC));
    side0.frame_start = (hcnt_q == '0) && (vcnt_q == '0);

    img0 = side0.de && (h32 >= IMG_X0) && (h32 < IMG_X0 + ImgW)
                    && (v32 >= IMG_Y0) && (v32 < IMG_Y0 + ImgH);
    x0   = 8'(h32 - IMG_X0);
    y0   = 8'(v32 - IMG_Y0);
  end

  always_comb begin
    frame_end = (hcnt_q == HLast) && (vcnt_q == VLast);

    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
    end

    // Bank only flips at the frame boundary so a frame is never torn.
    rbank_d = frame_end ? ~i_wbank : rbank_q;

    // Address holds outside the image window.
    raddr_d = img0 ? {rbank_q, y0, x0} : raddr_q;
  end

  always_ff @(posedge i_lcd_clk) begin
    if (i_rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      rbank_q <= 1'b1;
      raddr_q <= '0;
      side1_q <= SideIdle;
      side2_q <= SideIdle;
      side3_q <= SideIdle;
      img1_q  <= 1'b0;
      img2_q  <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      rbank_q <= rbank_d;
      raddr_q <= raddr_d;
      side1_q <= side0;
      side2_q <= side1_q;
      side3_q <= side2_q;
      img1_q  <= img0;
      img2_q  <= img1_q;
    end
  end

  // T3: colour register, aligned with side3_q.
  nes_palette_rom u_palette (
    .clk_i   (i_lcd_clk),
    .rst_i   (i_rst),
    .valid_i (img2_q),
    .idx_i   (i_rdata[5:0]),
    .rgb_o   (o_rgb)
  );

  assign o_raddr       = raddr_q;
  assign o_hsync       = side3_q.hsync_n;
  assign o_vsync       = side3_q.vsync_n;
  assign o_de          = side3_q.de;
  assign o_frame_start = side3_q.frame_start;

endmodule

// File: tb/tb_lcd_scanout.sv
// tb_lcd_scanout: self-checking bench for lcd_scanout.
// Horizontal timing is the panel default; the vertical active area is shortened
// to 20 lines (image rows 2..19) so several whole frames fit in a short run.
module tb_lcd_scanout;

  localparam int HA = 480, HFP = 2, HS = 41, HBP = 2;
  localparam int VA = 20, VFP = 2, VS = 10, VBP = 2;
  localparam int X0 = 112, Y0 = 2;
  localparam int HT = HA + HFP + HS + HBP;  // 525
  localparam int VT = VA + VFP + VS + VBP;  // 34
  localparam int FT = HT * VT;              // 17850
  localparam int NV = 8;

  localparam int SigHs = 0, SigVs = 1, SigFs = 2, SigDe = 3;

  localparam logic [23:0] PAL [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

  typedef struct {
    logic [7:0]  rdata;
    logic [23:0] rgb;
  } cvec_t;

  typedef struct packed {
    logic        de;
    logic        hs_n;
    logic        vs_n;
    logic        fs;
    logic        img;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
  } exp_t;

  logic        i_lcd_clk;
  logic        i_rst;
  logic        i_wbank;
  logic [16:0] o_raddr;
  logic [7:0]  i_rdata;
  logic        o_hsync, o_vsync, o_de, o_frame_start;
  logic [23:0] o_rgb;

  int tests = 0;
  int fails = 0;

  cvec_t       vec [NV];
  exp_t        q [$];
  logic        mon_on = 1'b0;
  int          mh, mv, tick_m;
  logic        mrb;
  logic [16:0] exp_raddr, prev_raddr;
  int          raddr_tick [NV];
  int          rgb_tick [NV];
  logic [23:0] cap_rgb [NV];
  int          fs_seen, de_cnt;
  int          n, t;

  lcd_scanout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .IMG_X0   (X0), .IMG_Y0 (Y0)
  ) dut (
    .i_lcd_clk     (i_lcd_clk),
    .i_rst         (i_rst),
    .i_wbank       (i_wbank),
    .o_raddr       (o_raddr),
    .i_rdata       (i_rdata),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_de          (o_de),
    .o_rgb         (o_rgb),
    .o_frame_start (o_frame_start)
  );

  initial i_lcd_clk = 1'b0;
  always #5 i_lcd_clk = ~i_lcd_clk;

  // Buffer contents: first NV pixels of row 0 come from the colour table,
  // everything else is a bank-dependent pattern that exercises bits 7:6.
  function automatic logic [7:0] ram_data(input logic [16:0] a);
    if (a[15:8] == 8'h00 && a[7:0] < 8'(NV)) return vec[a[2:0]].rdata;
    return (a[7:0] + {a[12:8], a[15:13]}) ^ {a[16], 7'h15};
  endfunction

  // Synchronous RAM: one clock read latency.
  always @(posedge i_lcd_clk) i_rdata <= ram_data(o_raddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_lcd_clk);
    #1;
  endtask

  function automatic logic sel_sig(input int which);
    case (which)
      SigHs:   return o_hsync;
      SigVs:   return o_vsync;
      SigFs:   return o_frame_start;
      default: return o_de;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int bound, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (sel_sig(which) !== val && cnt < bound);
  endtask

  // Scoreboard: the model walks the panel raster from reset release, pushes the
  // expected pixel for each T0 position and pops it when it reaches the outputs.
  always @(posedge i_lcd_clk) begin
    exp_t        e, r;
    logic [16:0] a;
    logic [7:0]  d;
    #1;
    if (mon_on) begin
      tick_m++;
      e.de   = (mh < HA) && (mv < VA);
      e.hs_n = !((mh >= HA + HFP) && (mh < HA + HFP + HS));
      e.vs_n = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
      e.fs   = (mh == 0) && (mv == 0);
      e.img  = e.de && (mh >= X0) && (mh < X0 + 256) && (mv >= Y0) && (mv < Y0 + 240);
      e.x    = 8'(mh - X0);
      e.y    = 8'(mv - Y0);
      a      = {mrb, e.y, e.x};
      d      = ram_data(a);
      e.rgb  = e.img ? PAL[d[5:0]] : 24'h000000;
      if (e.img) exp_raddr = a;

      check("raddr", 32'(o_raddr), 32'(exp_raddr));
      if (mh == X0 && mv == Y0) check("win_first", 32'(o_raddr), 32'({mrb, 16'h0000}));
      // last image pixel visible in this geometry: y=17, x=255
      if (mh == X0 + 255 && mv == VA - 1) check("win_last", 32'(o_raddr), 32'({mrb, 16'h11FF}));

      if (o_raddr !== prev_raddr && o_raddr[15:8] == 8'h00 && o_raddr[7:0] < 8'(NV))
        raddr_tick[o_raddr[2:0]] = tick_m;
      prev_raddr = o_raddr;

      q.push_back(e);
      if (q.size() == 3) begin
        r = q.pop_front();
        check("pixel", 32'({o_de, o_hsync, o_vsync, o_frame_start, o_rgb}),
              32'({r.de, r.hs_n, r.vs_n, r.fs, r.rgb}));
        if (r.img && r.y == 8'd0 && r.x < 8'(NV)) begin
          cap_rgb[r.x[2:0]]  = o_rgb;
          rgb_tick[r.x[2:0]] = tick_m;
        end
      end

      if (o_frame_start === 1'b1) fs_seen++;
      if (o_de === 1'b1 && fs_seen >= 1 && fs_seen <= 3) de_cnt++;

      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv  = 0;
          mrb = ~i_wbank;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
    end
  end

  initial begin
    vec[0] = '{8'h0F, 24'h000000};
    vec[1] = '{8'hCF, 24'h000000};
    vec[2] = '{8'h30, 24'hFCFCFC};
    vec[3] = '{8'h00, 24'h7C7C7C};
    vec[4] = '{8'h41, 24'h0000FC};
    vec[5] = '{8'h96, 24'hF83800};
    vec[6] = '{8'h2A, 24'h58D854};
    vec[7] = '{8'hFF, 24'h000000};
    for (int i = 0; i < NV; i++) begin
      raddr_tick[i] = 0;
      rgb_tick[i]   = 0;
      cap_rgb[i]    = 24'hxxxxxx;
    end

    i_rst   = 1'b1;
    i_wbank = 1'b0;
    repeat (3) tick();
    @(negedge i_lcd_clk);
    i_rst = 1'b0;
    repeat (1250) tick();

    // Reset mid-frame (while scanning image row 0) for 5 clocks.
    @(negedge i_lcd_clk);
    i_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_vals", 32'({o_raddr, o_hsync, o_vsync, o_de, o_frame_start}),
            32'({17'h0, 1'b1, 1'b1, 1'b0, 1'b0}));
      check("reset_rgb", 32'(o_rgb), 32'h0);
    end

    @(negedge i_lcd_clk);
    i_rst      = 1'b0;
    mh         = 0;
    mv         = 0;
    mrb        = 1'b1;
    tick_m     = 0;
    exp_raddr  = '0;
    prev_raddr = '0;
    fs_seen    = 0;
    de_cnt     = 0;
    q.delete();
    q.push_back('{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0, img: 1'b0, x: 8'h0, y: 8'h0, rgb: 24'h0});
    q.push_back('{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0, img: 1'b0, x: 8'h0, y: 8'h0, rgb: 24'h0});
    mon_on = 1'b1;

    // Frame 0: first pulse and sync geometry.
    wait_for(SigFs, 1'b1, 10, n);
    check("first_fs_latency", 32'(n), 32'd3);
    check("border_de_rgb", 32'({o_de, o_rgb}), 32'({1'b1, 24'h000000}));
    wait_for(SigHs, 1'b0, 2 * HT, n);
    check("de_to_hsync", 32'(n), 32'd482);
    t = n;
    wait_for(SigHs, 1'b1, 2 * HT, n);
    check("hsync_width", 32'(n), 32'd41);
    t += n;
    wait_for(SigHs, 1'b0, 2 * HT, n);
    check("hsync_period", 32'(n + 41), 32'd525);
    t += n;
    wait_for(SigVs, 1'b0, FT, n);
    t += n;
    check("vsync_start", 32'(t), 32'(22 * 525));
    wait_for(SigVs, 1'b1, FT, n);
    check("vsync_width", 32'(n), 32'(10 * 525));
    t += n;
    wait_for(SigFs, 1'b1, FT, n);
    t += n;
    check("frame_period", 32'(t), 32'(FT));

    // Frame 1: PPU switches to bank 1 mid-frame; reads stay on bank 1.
    repeat (5 * HT) tick();
    i_wbank = 1'b1;
    repeat (3 * HT + 200) tick();
    check("bank_hold", 32'(o_raddr[16]), 32'd1);

    // Frame 2: new bank takes effect at the boundary.
    wait_for(SigFs, 1'b1, FT + 10, n);
    repeat (8 * HT + 200) tick();
    check("bank_switch", 32'(o_raddr[16]), 32'd0);

    wait_for(SigFs, 1'b1, FT + 10, n);
    repeat (4) tick();
    mon_on = 1'b0;

    check("frames_seen", 32'(fs_seen), 32'd4);
    check("de_count", 32'(de_cnt), 32'(3 * 480 * 20));

    for (int i = 0; i < NV; i++) begin
      check($sformatf("colour[%0d]", i), 32'(cap_rgb[i]), 32'(vec[i].rgb));
      check($sformatf("colour_lat[%0d]", i), 32'(rgb_tick[i] - raddr_tick[i]), 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
